// File: rtl/rv32imf_apu_wb_buf.sv
// rv32imf_apu_wb_buf: in-order APU result queue that drains into register-file write port B.
// Define RV32IMF_APU_WB_BYPASS_EN to compile in the same-cycle bypass for an empty buffer.
module rv32imf_apu_wb_buf #(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         apu_rvalid_i,
  input  logic [31:0]                  apu_result_i,
  input  logic [4:0]                   apu_flags_i,
  input  logic [5:0]                   apu_waddr_i,
  input  logic                         wb_port_busy_i,
  input  logic                         is_decoding_i,
  input  logic [2:0][5:0]              read_regs_i,
  input  logic [2:0]                   read_regs_valid_i,
  output logic                         regfile_we_o,
  output logic [5:0]                   regfile_waddr_o,
  output logic [31:0]                  regfile_wdata_o,
  output logic                         fflags_we_o,
  output logic [4:0]                   fflags_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         stall_o,
  output logic                         buf_read_dep_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [5:0]  waddr_q  [DEPTH];
  logic [31:0] result_q [DEPTH];
  logic [4:0]  flags_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt, wr_ptr_nxt;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic head_ret, byp_ret, full, push_req, enq, deq, drop, retire;
  logic [5:0]  ret_waddr;
  logic [31:0] ret_wdata;
  logic [4:0]  ret_flags;
  logic        hit;

  assign full     = (count_q == CW'(DEPTH));
  assign head_ret = rst_ni && (count_q != '0) && !wb_port_busy_i;
`ifdef RV32IMF_APU_WB_BYPASS_EN
  assign byp_ret  = rst_ni && (count_q == '0) && apu_rvalid_i && !wb_port_busy_i;
`else
  assign byp_ret  = 1'b0;
`endif
  assign deq      = head_ret;
  assign push_req = rst_ni && apu_rvalid_i && !byp_ret;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign enq      = push_req && (!full || deq);
  assign drop     = push_req && full && !deq;
  assign retire   = head_ret || byp_ret;

  assign rd_ptr_nxt = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
  assign wr_ptr_nxt = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);

  always_comb begin
    ret_waddr = '0;
    ret_wdata = '0;
    ret_flags = '0;
    if (head_ret) begin
      ret_waddr = waddr_q[rd_ptr_q];
      ret_wdata = result_q[rd_ptr_q];
      ret_flags = flags_q[rd_ptr_q];
    end else if (byp_ret) begin
      ret_waddr = apu_waddr_i;
      ret_wdata = apu_result_i;
      ret_flags = apu_flags_i;
    end
  end

  // Integer x0 results still update fcsr flags but never touch the regfile.
  assign regfile_we_o    = retire && (ret_waddr != 6'd0);
  assign regfile_waddr_o = ret_waddr;
  assign regfile_wdata_o = ret_wdata;
  assign fflags_we_o     = retire;
  assign fflags_o        = ret_flags;

  assign count_o    = count_q;
  assign stall_o    = (count_q >= CW'(DEPTH - 2));
  assign overflow_o = overflow_q;

  always_comb begin
    hit = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (read_regs_valid_i[r]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (valid_q[e] && (waddr_q[e] == read_regs_i[r])) hit = 1'b1;
        end
        if (enq && (apu_waddr_i == read_regs_i[r])) hit = 1'b1;
      end
    end
  end
  assign buf_read_dep_o = rst_ni && is_decoding_i && hit;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      waddr_q[wr_ptr_q]  <= apu_waddr_i;
      result_q[wr_ptr_q] <= apu_result_i;
      flags_q[wr_ptr_q]  <= apu_flags_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Clear before set: when full, the freed head slot is the one being refilled.
      if (deq) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_nxt;
      end
      if (enq) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_nxt;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32imf_apu_wb_buf.sv
// Self-checking bench for rv32imf_apu_wb_buf: directed scenarios plus a random run against a queue model.
module tb_rv32imf_apu_wb_buf;

  localparam int DEPTH = 4;
`ifdef RV32IMF_APU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             apu_rvalid_i;
  logic [31:0]      apu_result_i;
  logic [4:0]       apu_flags_i;
  logic [5:0]       apu_waddr_i;
  logic             wb_port_busy_i;
  logic             is_decoding_i;
  logic [2:0][5:0]  read_regs_i;
  logic [2:0]       read_regs_valid_i;
  logic             regfile_we_o;
  logic [5:0]       regfile_waddr_o;
  logic [31:0]      regfile_wdata_o;
  logic             fflags_we_o;
  logic [4:0]       fflags_o;
  logic [2:0]       count_o;
  logic             stall_o;
  logic             buf_read_dep_o;
  logic             overflow_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    logic [4:0]  f;
  } ent_t;

  rv32imf_apu_wb_buf #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
    .apu_flags_i(apu_flags_i), .apu_waddr_i(apu_waddr_i),
    .wb_port_busy_i(wb_port_busy_i), .is_decoding_i(is_decoding_i),
    .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i),
    .regfile_we_o(regfile_we_o), .regfile_waddr_o(regfile_waddr_o),
    .regfile_wdata_o(regfile_wdata_o), .fflags_we_o(fflags_we_o),
    .fflags_o(fflags_o), .count_o(count_o), .stall_o(stall_o),
    .buf_read_dep_o(buf_read_dep_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    apu_rvalid_i      = 1'b0;
    apu_result_i      = '0;
    apu_flags_i       = '0;
    apu_waddr_i       = '0;
    wb_port_busy_i    = 1'b0;
    is_decoding_i     = 1'b0;
    read_regs_i       = '0;
    read_regs_valid_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d, input logic [4:0] f);
    apu_rvalid_i = 1'b1;
    apu_waddr_i  = a;
    apu_result_i = d;
    apu_flags_i  = f;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    push(6'h25, 32'hDEAD_BEEF, 5'h1F);
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    checks++;
    if ({regfile_we_o, regfile_waddr_o, regfile_wdata_o, fflags_we_o, fflags_o} !== '0) begin
      errors++;
      $display("FAIL reset_retire_outs: got we=%b waddr=%h wdata=%h fwe=%b ff=%h, want all 0",
               regfile_we_o, regfile_waddr_o, regfile_wdata_o, fflags_we_o, fflags_o);
    end
    checks++;
    if ({count_o, stall_o, buf_read_dep_o, overflow_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got count=%0d stall=%b dep=%b ovf=%b, want 0",
               count_o, stall_o, buf_read_dep_o, overflow_o);
    end
    rst_ni = 1'b1;
    idle_inputs();
    next_cycle();
    checks++;
    if (count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_count_after_release: got %0d want 0", count_o);
    end
  endtask

  task automatic test_bypass();
    push(6'h25, 32'h3F80_0000, 5'h01);
    @(negedge clk_i);
    checks++;
    if (regfile_we_o !== BYP || count_o !== 3'd0) begin
      errors++;
      $display("FAIL bypass_cycle0: got we=%b count=%0d want we=%b count=0", regfile_we_o, count_o, BYP);
    end
    if (BYP) begin
      checks++;
      if (regfile_waddr_o !== 6'h25 || regfile_wdata_o !== 32'h3F80_0000 ||
          fflags_o !== 5'h01 || fflags_we_o !== 1'b1) begin
        errors++;
        $display("FAIL bypass_data: got waddr=%h wdata=%h ff=%h fwe=%b want 25 3f800000 01 1",
                 regfile_waddr_o, regfile_wdata_o, fflags_o, fflags_we_o);
      end
    end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (regfile_we_o !== !BYP || count_o !== (BYP ? 3'd0 : 3'd1)) begin
      errors++;
      $display("FAIL bypass_cycle1: got we=%b count=%0d want we=%b count=%0d",
               regfile_we_o, count_o, !BYP, BYP ? 0 : 1);
    end
    if (!BYP) begin
      checks++;
      if (regfile_waddr_o !== 6'h25 || regfile_wdata_o !== 32'h3F80_0000 || fflags_o !== 5'h01) begin
        errors++;
        $display("FAIL queued_data: got waddr=%h wdata=%h ff=%h want 25 3f800000 01",
                 regfile_waddr_o, regfile_wdata_o, fflags_o);
      end
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (regfile_we_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL bypass_drained: got we=%b count=%0d want 0 0", regfile_we_o, count_o);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [5:0] addrs [3];
    logic [2:0] exp_cnt;
    addrs[0] = 6'h0A; addrs[1] = 6'h2B; addrs[2] = 6'h0C;
    wb_port_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(addrs[i], 32'h1000_0000 + i, 5'(i + 1));
      @(negedge clk_i);
      checks++;
      if (count_o !== 3'(i) || stall_o !== (i >= 2) || regfile_we_o !== 1'b0) begin
        errors++;
        $display("FAIL contention_fill%0d: got count=%0d stall=%b we=%b want %0d %b 0",
                 i, count_o, stall_o, regfile_we_o, i, i >= 2);
      end
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      exp_cnt = 3'(3 - i);
      checks++;
      if (regfile_we_o !== 1'b1 || regfile_waddr_o !== addrs[i] ||
          regfile_wdata_o !== 32'h1000_0000 + i || count_o !== exp_cnt ||
          stall_o !== (exp_cnt >= 3'd2)) begin
        errors++;
        $display("FAIL contention_drain%0d: got we=%b waddr=%h wdata=%h count=%0d stall=%b want 1 %h %h %0d %b",
                 i, regfile_we_o, regfile_waddr_o, regfile_wdata_o, count_o, stall_o,
                 addrs[i], 32'h1000_0000 + i, exp_cnt, exp_cnt >= 3'd2);
      end
      next_cycle();
    end
    @(negedge clk_i);
    checks++;
    if (regfile_we_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL contention_empty: got we=%b count=%0d want 0 0", regfile_we_o, count_o);
    end
    next_cycle();
  endtask

  task automatic test_x0();
    wb_port_busy_i = 1'b1;
    push(6'd0, 32'h1234_5678, 5'h10);
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (regfile_we_o !== 1'b0 || fflags_we_o !== 1'b1 || fflags_o !== 5'h10 ||
        regfile_wdata_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL x0_dest: got we=%b fwe=%b ff=%h wdata=%h want 0 1 10 12345678",
               regfile_we_o, fflags_we_o, fflags_o, regfile_wdata_o);
    end
    next_cycle();
  endtask

  task automatic test_hazard();
    wb_port_busy_i = 1'b1;
    push(6'h21, 32'hAAAA_0001, 5'h00);
    next_cycle();
    apu_rvalid_i      = 1'b0;
    is_decoding_i     = 1'b1;
    read_regs_i[0]    = 6'h05;
    read_regs_i[1]    = 6'h21;
    read_regs_i[2]    = 6'h0A;
    read_regs_valid_i = 3'b111;
    @(negedge clk_i);
    checks++;
    if (buf_read_dep_o !== 1'b1) begin
      errors++;
      $display("FAIL hazard_queued: got %b want 1", buf_read_dep_o);
    end
    is_decoding_i = 1'b0;
    #1;
    checks++;
    if (buf_read_dep_o !== 1'b0) begin
      errors++;
      $display("FAIL hazard_not_decoding: got %b want 0", buf_read_dep_o);
    end
    is_decoding_i     = 1'b1;
    read_regs_valid_i = 3'b101;
    #1;
    checks++;
    if (buf_read_dep_o !== 1'b0) begin
      errors++;
      $display("FAIL hazard_invalid_src: got %b want 0", buf_read_dep_o);
    end
    push(6'h0A, 32'hAAAA_0002, 5'h00);
    #1;
    checks++;
    if (buf_read_dep_o !== 1'b1) begin
      errors++;
      $display("FAIL hazard_incoming: got %b want 1", buf_read_dep_o);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (count_o !== 3'd0) begin
      errors++;
      $display("FAIL hazard_drain: got count=%0d want 0", count_o);
    end
    next_cycle();
  endtask

  task automatic test_overflow();
    wb_port_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(6'(i + 1), 32'hB000_0000 + i, 5'h00);
      next_cycle();
    end
    apu_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b count=%0d want 1 4", overflow_o, count_o);
    end
    next_cycle();
    wb_port_busy_i = 1'b0;
    push(6'h2E, 32'hB000_00EE, 5'h02);
    @(negedge clk_i);
    checks++;
    if (regfile_we_o !== 1'b1 || regfile_waddr_o !== 6'd1) begin
      errors++;
      $display("FAIL overflow_full_deq: got we=%b waddr=%h want 1 01", regfile_we_o, regfile_waddr_o);
    end
    next_cycle();
    idle_inputs();
    wb_port_busy_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 3'd4) begin
      errors++;
      $display("FAIL overflow_sticky: got ovf=%b count=%0d want 1 4", overflow_o, count_o);
    end
    next_cycle();
    wb_port_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [5:0] exp_a;
      exp_a = (i < 3) ? 6'(i + 2) : 6'h2E;
      @(negedge clk_i);
      checks++;
      if (regfile_waddr_o !== exp_a || regfile_we_o !== 1'b1) begin
        errors++;
        $display("FAIL overflow_order%0d: got waddr=%h we=%b want %h 1", i, regfile_waddr_o, regfile_we_o, exp_a);
      end
      next_cycle();
    end
    do_reset();
    @(negedge clk_i);
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow_reset: got %b want 0", overflow_o);
    end
    next_cycle();
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t inc, e;
    logic [5:0] pool [8];
    logic model_ovf, do_rst, ret_head, ret_byp, accepted, ret, exp_dep;
    pool[0] = 6'h00; pool[1] = 6'h01; pool[2] = 6'h07; pool[3] = 6'h21;
    pool[4] = 6'h25; pool[5] = 6'h3F; pool[6] = 6'h10; pool[7] = 6'h30;
    do_reset();
    model_ovf = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      do_rst            = ($urandom_range(0, 199) == 0);
      rst_ni            = !do_rst;
      apu_rvalid_i      = ($urandom_range(0, 9) < 6);
      apu_waddr_i       = pool[$urandom_range(0, 7)];
      apu_result_i      = $urandom;
      apu_flags_i       = 5'($urandom);
      wb_port_busy_i    = ($urandom_range(0, 9) < 5);
      is_decoding_i     = $urandom_range(0, 1);
      for (int r = 0; r < 3; r++) read_regs_i[r] = pool[$urandom_range(0, 7)];
      read_regs_valid_i = 3'($urandom);
      inc.a = apu_waddr_i; inc.d = apu_result_i; inc.f = apu_flags_i;

      ret_head = (q.size() > 0) && !wb_port_busy_i;
      ret_byp  = BYP && (q.size() == 0) && apu_rvalid_i && !wb_port_busy_i;
      ret      = ret_head || ret_byp;
      accepted = apu_rvalid_i && !ret_byp && ((q.size() < DEPTH) || ret_head);
      e.a = '0; e.d = '0; e.f = '0;
      if (ret_head) e = q[0];
      else if (ret_byp) e = inc;
      exp_dep = 1'b0;
      for (int r = 0; r < 3; r++) begin
        if (read_regs_valid_i[r]) begin
          foreach (q[k]) if (q[k].a == read_regs_i[r]) exp_dep = 1'b1;
          if (accepted && inc.a == read_regs_i[r]) exp_dep = 1'b1;
        end
      end
      exp_dep = exp_dep && is_decoding_i;

      @(negedge clk_i);
      if (!do_rst) begin
        checks++;
        if (regfile_we_o !== (ret && e.a != 6'd0) || fflags_we_o !== ret) begin
          errors++;
          $display("FAIL rand_we c%0d: got we=%b fwe=%b want %b %b",
                   cyc, regfile_we_o, fflags_we_o, ret && e.a != 6'd0, ret);
        end
        checks++;
        if (regfile_waddr_o !== e.a || regfile_wdata_o !== e.d || fflags_o !== e.f) begin
          errors++;
          $display("FAIL rand_data c%0d: got %h %h %h want %h %h %h", cyc,
                   regfile_waddr_o, regfile_wdata_o, fflags_o, e.a, e.d, e.f);
        end
        checks++;
        if (count_o !== 3'(q.size()) || stall_o !== ((DEPTH - q.size()) <= 2) ||
            overflow_o !== model_ovf) begin
          errors++;
          $display("FAIL rand_state c%0d: got count=%0d stall=%b ovf=%b want %0d %b %b", cyc,
                   count_o, stall_o, overflow_o, q.size(), (DEPTH - q.size()) <= 2, model_ovf);
        end
        checks++;
        if (buf_read_dep_o !== exp_dep) begin
          errors++;
          $display("FAIL rand_dep c%0d: got %b want %b", cyc, buf_read_dep_o, exp_dep);
        end
      end
      @(posedge clk_i);
      if (do_rst) begin
        q.delete();
        model_ovf = 1'b0;
      end else begin
        if (ret_head) void'(q.pop_front());
        if (accepted) q.push_back(inc);
        else if (apu_rvalid_i && !ret_byp) model_ovf = 1'b1;
      end
      #1;
    end
    rst_ni = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    test_reset();
    test_bypass();
    test_back_to_back();
    test_x0();
    test_hazard();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
